apb_button_ctrl: RTL and testbench

APB-slave controller for the board push-buttons. It synchronises and debounces up to four button inputs and detects press and release edges. It keeps sticky W1C event status, per-button 8-bit press counters, and drives one level interrupt to the CPU. It sits on the peripheral APB segment and replaces raw polling of button pins by software.

---
 rtl/apb_button_ctrl.sv | 165 ++++++++++++++++
 tb/tb_apb_button_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_button_ctrl.sv
// APB slave for board push-buttons: 2-flop sync, per-button debounce, press/release
// edge detection, sticky W1C status, 8-bit press counters and a level interrupt.
module apb_button_ctrl #(
  parameter int unsigned ADDRWIDTH  = 12,
  parameter int unsigned NBTN       = 4,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter logic [15:0] DB_RESET   = 16'd50000
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 psel,
  input  logic [ADDRWIDTH-1:0] paddr,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [31:0]          pwdata,
  output logic [31:0]          prdata,
  output logic                 pready,
  output logic                 pslverr,
  input  logic [NBTN-1:0]      btn_in,
  output logic                 irq
);

  localparam int unsigned CNTW = 16;
  localparam int unsigned PCW  = 8;

  localparam logic [NBTN-1:0] IDLE_LVL = (ACTIVE_LOW != 0) ? {NBTN{1'b1}} : {NBTN{1'b0}};
  localparam logic [15:0]     BTN_MASK = 16'((32'd1 << NBTN) - 32'd1);
  localparam logic [31:0]     EVT_MASK = {BTN_MASK, BTN_MASK};

  localparam logic [2:0] A_RAW   = 3'd0;
  localparam logic [2:0] A_STATE = 3'd1;
  localparam logic [2:0] A_DBCNT = 3'd2;
  localparam logic [2:0] A_IE    = 3'd3;
  localparam logic [2:0] A_IS    = 3'd4;
  localparam logic [2:0] A_PCNT  = 3'd5;

  logic [NBTN-1:0] r_sync1;
  logic [NBTN-1:0] r_sync2;
  logic [NBTN-1:0] r_state;
  logic [CNTW-1:0] r_dbc  [NBTN];
  logic [PCW-1:0]  r_pcnt [NBTN];
  logic [15:0]     r_dbcnt;
  logic [31:0]     r_ie;
  logic [31:0]     r_is;
  logic [31:0]     r_prdata;
  logic            r_irq;

  logic [NBTN-1:0] w_pressed;
  logic [NBTN-1:0] w_flip;
  logic [NBTN-1:0] w_rise;
  logic [NBTN-1:0] w_fall;
  logic [CNTW:0]   w_cnt_inc [NBTN];
  logic [15:0]     w_thr;
  logic [2:0]      w_sel;
  logic            w_wr;
  logic            w_rd;
  logic [31:0]     w_is_set;
  logic [31:0]     w_is_clr;
  logic [31:0]     w_rdata;
  logic            w_unused;

  assign pready   = 1'b1;
  assign pslverr  = 1'b0;
  assign prdata   = r_prdata;
  assign irq      = r_irq;
  assign w_unused = ^{paddr, pwdata};

  assign w_sel     = paddr[4:2];
  assign w_wr      = psel & penable & pwrite;
  assign w_rd      = psel & ~penable & ~pwrite;
  assign w_pressed = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
  assign w_thr     = (r_dbcnt == 16'd0) ? 16'd1 : r_dbcnt;

  // Two-flop synchroniser, idles at the released pin level
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_sync1 <= IDLE_LVL;
      r_sync2 <= IDLE_LVL;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // Flip when the disagreement run reaches the threshold; >= also covers a threshold lowered mid-count
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < int'(NBTN); i++) begin
      w_cnt_inc[i] = {1'b0, r_dbc[i]} + 17'd1;
      w_flip[i]    = (w_pressed[i] != r_state[i]) && (w_cnt_inc[i] >= {1'b0, w_thr});
    end
  end

  assign w_rise = w_flip & ~r_state;
  assign w_fall = w_flip & r_state;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= '0;
      for (int i = 0; i < int'(NBTN); i++) r_dbc[i] <= '0;
    end else begin
      r_state <= r_state ^ w_flip;
      for (int i = 0; i < int'(NBTN); i++) begin
        if ((w_pressed[i] == r_state[i]) || w_flip[i]) r_dbc[i] <= '0;
        else                                            r_dbc[i] <= w_cnt_inc[i][CNTW-1:0];
      end
    end
  end

  always_comb begin
    w_is_set               = '0;
    w_is_set[NBTN-1:0]     = w_rise;
    w_is_set[16 +: NBTN]   = w_fall;
    w_is_clr               = (w_wr && (w_sel == A_IS)) ? (pwdata & EVT_MASK) : 32'd0;
  end

  // Control/status registers; a hardware set wins over a W1C of the same bit
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_dbcnt <= DB_RESET;
      r_ie    <= '0;
      r_is    <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr && (w_sel == A_DBCNT)) r_dbcnt <= pwdata[15:0];
      if (w_wr && (w_sel == A_IE))    r_ie    <= pwdata & EVT_MASK;
      r_is  <= (r_is & ~w_is_clr) | w_is_set;
      r_irq <= |(r_is & r_ie);
    end
  end

  // Press counters: any PCNT write clears, a coincident press still counts
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < int'(NBTN); i++) r_pcnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NBTN); i++) begin
        if (w_wr && (w_sel == A_PCNT)) r_pcnt[i] <= {7'd0, w_rise[i]};
        else                           r_pcnt[i] <= r_pcnt[i] + {7'd0, w_rise[i]};
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      A_RAW:   w_rdata[NBTN-1:0] = w_pressed;
      A_STATE: w_rdata[NBTN-1:0] = r_state;
      A_DBCNT: w_rdata[15:0]     = r_dbcnt;
      A_IE:    w_rdata           = r_ie;
      A_IS:    w_rdata           = r_is;
      A_PCNT: begin
        for (int i = 0; i < int'(NBTN); i++) w_rdata[PCW*i +: PCW] = r_pcnt[i];
      end
      default: w_rdata = '0;
    endcase
  end

  // Read data captured in the setup phase so it is valid during access
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)  r_prdata <= '0;
    else if (w_rd) r_prdata <= w_rdata;
  end

endmodule

// File: tb/tb_apb_button_ctrl.sv
// Bench for apb_button_ctrl: register table, hand-timed corner sequences and random
// pin activity checked against a timestamp-based reference model.
module tb_apb_button_ctrl;

  localparam logic [11:0] A_RAW   = 12'h000;
  localparam logic [11:0] A_STATE = 12'h004;
  localparam logic [11:0] A_DBCNT = 12'h008;
  localparam logic [11:0] A_IE    = 12'h00C;
  localparam logic [11:0] A_IS    = 12'h010;
  localparam logic [11:0] A_PCNT  = 12'h014;
  localparam logic [31:0] EVT_MASK = 32'h000F000F;

  logic        pclk, presetn, psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, irq;
  logic [3:0]  btn_in;

  apb_button_ctrl #(
    .ADDRWIDTH(12), .NBTN(4), .ACTIVE_LOW(1), .DB_RESET(16'd50000)
  ) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .paddr(paddr), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .btn_in(btn_in), .irq(irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_cmp, n_err;
  bit r_rand;
  logic [31:0] rd;

  // Reference model: a button flips once it has disagreed with its debounced
  // state for thr consecutive edges since the last edge where it agreed.
  bit [3:0]    m_pin_q[$];
  int          m_edge;
  int          m_last[4];
  logic [3:0]  m_state;
  logic [31:0] m_is, m_ie, m_prdata;
  logic [7:0]  m_pcnt[4];
  logic [15:0] m_dbcnt;
  logic        m_irq;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    string       name;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pin_q.delete();
    m_pin_q.push_back(4'b0);
    m_pin_q.push_back(4'b0);
    m_edge = 0;
    for (int i = 0; i < 4; i++) begin
      m_last[i] = 0;
      m_pcnt[i] = 8'd0;
    end
    m_state  = '0;
    m_is     = '0;
    m_ie     = '0;
    m_prdata = '0;
    m_dbcnt  = 16'd50000;
    m_irq    = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      3'd0: v = {28'd0, m_pin_q[0]};
      3'd1: v = {28'd0, m_state};
      3'd2: v = {16'd0, m_dbcnt};
      3'd3: v = m_ie;
      3'd4: v = m_is;
      3'd5: v = {m_pcnt[3], m_pcnt[2], m_pcnt[1], m_pcnt[0]};
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_step();
    logic [31:0] rdv;
    logic        irq_n;
    bit [3:0]    s;
    logic [3:0]  rise, fall;
    logic [2:0]  a;
    bit          rd_en, wr_en;
    int          thr;
    if (presetn !== 1'b1) return;
    m_edge++;
    a     = paddr[4:2];
    rd_en = psel && !penable && !pwrite;
    wr_en = psel && penable && pwrite;
    rdv   = model_read(a);
    irq_n = |(m_is & m_ie);
    m_pin_q.push_back(~btn_in);
    s     = m_pin_q.pop_front();
    thr   = (m_dbcnt == 16'd0) ? 1 : int'(m_dbcnt);
    rise  = '0;
    fall  = '0;
    for (int i = 0; i < 4; i++) begin
      if (s[i] == m_state[i]) m_last[i] = m_edge;
      else if (m_edge - m_last[i] >= thr) begin
        if (m_state[i]) fall[i] = 1'b1;
        else            rise[i] = 1'b1;
        m_state[i] = ~m_state[i];
        m_last[i]  = m_edge;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (wr_en && a == 3'd5) m_pcnt[i] = rise[i] ? 8'd1 : 8'd0;
      else                    m_pcnt[i] = m_pcnt[i] + (rise[i] ? 8'd1 : 8'd0);
    end
    if (wr_en && a == 3'd4) m_is = m_is & ~(pwdata & EVT_MASK);
    m_is = m_is | {12'd0, fall, 12'd0, rise};
    if (wr_en && a == 3'd2) m_dbcnt = pwdata[15:0];
    if (wr_en && a == 3'd3) m_ie = pwdata & EVT_MASK;
    if (rd_en) m_prdata = rdv;
    m_irq = irq_n;
  endtask

  task automatic tick();
    @(posedge pclk);
    model_step();
    @(negedge pclk);
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    if (r_rand)
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 4) == 0) btn_in[i] = ~btn_in[i];
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    tick();
    penable = 1'b1;
    d = prdata;
    check($sformatf("model rd@%03h", a), d, m_prdata);
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    model_reset();
    ticks(2);
    presetn = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; r_rand = 1'b0;
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; btn_in = 4'hF;
    model_reset();
    @(negedge pclk);
    do_reset();

    check("rst irq", {31'd0, irq}, 32'd0);
    check("rst prdata", prdata, 32'd0);
    check("pready", {31'd0, pready}, 32'd1);
    check("pslverr", {31'd0, pslverr}, 32'd0);

    // Register table: reset values, masking, aliasing and reserved space
    tbl.push_back('{1'b0, A_RAW,   32'h0,        "rst RAW"});
    tbl.push_back('{1'b0, A_STATE, 32'h0,        "rst STATE"});
    tbl.push_back('{1'b0, A_DBCNT, 32'h0000C350, "rst DBCNT"});
    tbl.push_back('{1'b0, A_IE,    32'h0,        "rst IE"});
    tbl.push_back('{1'b0, A_IS,    32'h0,        "rst IS"});
    tbl.push_back('{1'b0, A_PCNT,  32'h0,        "rst PCNT"});
    tbl.push_back('{1'b0, 12'h018, 32'h0,        "rst rsvd18"});
    tbl.push_back('{1'b0, 12'h01C, 32'h0,        "rst rsvd1C"});
    tbl.push_back('{1'b1, A_IE,    32'hFFFFFFFF, ""});
    tbl.push_back('{1'b0, A_IE,    32'h000F000F, "IE mask"});
    tbl.push_back('{1'b1, A_DBCNT, 32'hABCD1234, ""});
    tbl.push_back('{1'b0, A_DBCNT, 32'h00001234, "DBCNT mask"});
    tbl.push_back('{1'b0, 12'hF08, 32'h00001234, "addr alias"});
    tbl.push_back('{1'b1, 12'h018, 32'hFFFFFFFF, ""});
    tbl.push_back('{1'b0, 12'h018, 32'h0,        "rsvd write"});
    tbl.push_back('{1'b1, A_RAW,   32'hFFFFFFFF, ""});
    tbl.push_back('{1'b0, A_RAW,   32'h0,        "RAW ro"});
    tbl.push_back('{1'b1, A_IS,    32'hFFFFFFFF, ""});
    tbl.push_back('{1'b0, A_IS,    32'h0,        "IS idle w1c"});
    tbl.push_back('{1'b1, A_IE,    32'h0,        ""});
    tbl.push_back('{1'b0, A_IE,    32'h0,        "IE clear"});
    tbl.push_back('{1'b1, A_DBCNT, 32'h0000000A, ""});
    tbl.push_back('{1'b0, A_DBCNT, 32'h0000000A, "DBCNT=10"});
    foreach (tbl[i]) begin
      if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].data);
      else begin
        apb_read(tbl[i].addr, rd);
        check(tbl[i].name, rd, tbl[i].data);
      end
    end

    // Glitch of 8 cycles against a threshold of 10
    btn_in[0] = 1'b0;
    ticks(8);
    btn_in[0] = 1'b1;
    ticks(15);
    apb_read(A_STATE, rd); check("glitch STATE", rd, 32'h0);
    apb_read(A_IS, rd);    check("glitch IS", rd, 32'h0);
    apb_read(A_PCNT, rd);  check("glitch PCNT", rd, 32'h0);

    // Press: STATE flips on the 12th edge after the pin edge, irq one edge later
    apb_write(A_IE, 32'h1);
    btn_in[0] = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_STATE;
    for (int k = 1; k <= 13; k++) begin
      tick();
      check($sformatf("press STATE@%0d", k), prdata, (k >= 13) ? 32'h1 : 32'h0);
      if (k == 12) check("press irq@12", {31'd0, irq}, 32'd0);
      if (k == 13) check("press irq@13", {31'd0, irq}, 32'd1);
    end
    paddr = A_PCNT;
    tick();
    check("press PCNT", prdata, 32'h1);
    paddr = A_IS;
    tick();
    check("press IS", prdata, 32'h1);
    psel = 1'b0;

    // Release and W1C
    btn_in[0] = 1'b1;
    ticks(14);
    apb_read(A_IS, rd); check("release IS", rd, 32'h00010001);
    apb_write(A_IS, 32'h1);
    apb_read(A_IS, rd); check("w1c IS", rd, 32'h00010000);
    check("w1c irq", {31'd0, irq}, 32'd0);

    // Hardware press on btn1 coinciding with W1C of IS[1]
    apb_write(A_IE, 32'h3);
    btn_in[1] = 1'b0;
    ticks(14);
    check("btn1 irq", {31'd0, irq}, 32'd1);
    btn_in[1] = 1'b1;
    ticks(14);
    btn_in[1] = 1'b0;
    ticks(10);
    apb_write(A_IS, 32'h2);
    check("collide irq@12", {31'd0, irq}, 32'd1);
    tick();
    check("collide irq@13", {31'd0, irq}, 32'd1);
    apb_read(A_IS, rd); check("collide IS", rd, 32'h00030002);
    btn_in[1] = 1'b1;
    ticks(14);

    // 256 presses wrap the counter; then a press coinciding with a clear-write
    apb_write(A_DBCNT, 32'h1);
    for (int n = 0; n < 256; n++) begin
      btn_in[2] = 1'b0;
      ticks(4);
      btn_in[2] = 1'b1;
      ticks(4);
    end
    apb_read(A_PCNT, rd);
    check("wrap byte2", {24'd0, rd[23:16]}, 32'h0);
    check("wrap PCNT", rd, 32'h00000201);
    btn_in[2] = 1'b0;
    tick();
    apb_write(A_PCNT, 32'h0);
    apb_read(A_PCNT, rd); check("clr+press PCNT", rd, 32'h00010000);
    btn_in[2] = 1'b1;
    ticks(4);

    // Reset in the middle of a debounce
    apb_write(A_DBCNT, 32'd10);
    btn_in[0] = 1'b0;
    ticks(6);
    do_reset();
    check("mid-rst irq", {31'd0, irq}, 32'd0);
    apb_read(A_STATE, rd); check("mid-rst STATE", rd, 32'h0);
    apb_read(A_IS, rd);    check("mid-rst IS", rd, 32'h0);
    apb_read(A_DBCNT, rd); check("mid-rst DBCNT", rd, 32'h0000C350);
    apb_read(A_PCNT, rd);  check("mid-rst PCNT", rd, 32'h0);
    btn_in[0] = 1'b1;
    ticks(4);

    // Random pin activity with interleaved register traffic
    apb_write(A_DBCNT, 32'd4);
    apb_write(A_IE, EVT_MASK);
    r_rand = 1'b1;
    for (int it = 0; it < 30; it++) begin
      ticks(int'($urandom_range(20, 60)));
      apb_read(12'($urandom_range(0, 7) << 2), rd);
      if (it % 3 == 0) apb_write(A_IS, $urandom);
      if (it % 5 == 0) apb_write(A_DBCNT, 32'($urandom_range(0, 6)));
      if (it % 7 == 0) apb_write(A_PCNT, 32'h0);
    end
    r_rand = 1'b0;
    btn_in = 4'hF;
    ticks(20);
    apb_read(A_STATE, rd); check("final STATE", rd, 32'h0);
    apb_read(A_IS, rd);
    apb_read(A_PCNT, rd);
    apb_read(A_RAW, rd);   check("final RAW", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
